// File: rtl/instr_mem_loader.sv
// Framed byte-stream loader: assembles 16-bit instructions from a SYNC/N/data/CHK frame,
// writes them to instruction memory and holds the core while a program is loading.
module instr_mem_loader #(
  parameter int         DEPTH   = 16,
  parameter int         ADDR_W  = 4,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int         TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, COUNT, DATA_HI, DATA_LO, CHECK, DONE, ERR
  } state_t;

  state_t              state_q;
  logic                rx_ready_q, mem_we_q, cpu_hold_q, load_done_q, load_err_q;
  logic [ADDR_W-1:0]   mem_addr_q, idx_q, last_q;
  logic [15:0]         mem_wdata_q;
  logic [7:0]          hi_q, chk_q;
  logic [TW-1:0]       timer_q;
  logic                accept, busy;

  assign accept = rx_valid && rx_ready_q;
  assign busy   = (state_q == COUNT) || (state_q == DATA_HI) ||
                  (state_q == DATA_LO) || (state_q == CHECK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      chk_q       <= '0;
      timer_q     <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      hi_q        <= '0;
    end else begin
      mem_we_q    <= 1'b0;
      load_done_q <= 1'b0;
      rx_ready_q  <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept && rx_data == SYNC) begin
            state_q    <= COUNT;
            cpu_hold_q <= 1'b1;
            load_err_q <= 1'b0;
            chk_q      <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
          end
        end
        COUNT: begin
          if (accept) begin
            if (rx_data == 8'd0 || {1'b0, rx_data} > DEPTH9) begin
              state_q    <= ERR;
              load_err_q <= 1'b1;
              rx_ready_q <= 1'b0;
            end else begin
              last_q  <= ADDR_W'(rx_data - 8'd1);
              state_q <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            hi_q    <= rx_data;
            chk_q   <= chk_q ^ rx_data;
            state_q <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (accept) begin
            chk_q       <= chk_q ^ rx_data;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= idx_q;
            mem_wdata_q <= {hi_q, rx_data};
            idx_q       <= idx_q + 1'b1;
            state_q     <= (idx_q == last_q) ? CHECK : DATA_HI;
          end
        end
        CHECK: begin
          if (accept) begin
            rx_ready_q <= 1'b0;
            if (rx_data == chk_q) begin
              state_q     <= DONE;
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
            end else begin
              state_q    <= ERR;
              load_err_q <= 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // Inter-byte watchdog; only idle cycles inside a frame reach the abort branch.
      if (busy) begin
        if (accept) begin
          timer_q <= '0;
        end else if (timer_q == TLAST) begin
          timer_q    <= '0;
          state_q    <= ERR;
          load_err_q <= 1'b1;
          rx_ready_q <= 1'b0;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed frames plus randomized frames checked against a
// frame-level model (expected writes, checksum outcome, hold/error status).
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready, mem_we, cpu_hold, load_done, load_err;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;

  int checks = 0, failures = 0, we_cnt = 0, stalls = 0;
  logic [7:0] frm[$];

  instr_mem_loader #(.DEPTH(16), .ADDR_W(4), .SYNC(8'hA5), .TIMEOUT(1024)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a byte and return at the negedge after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      checks++;
      failures++;
      $display("FAIL rdy_wait observed=%0d expected=<20", w);
    end
    stalls += w;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_ready", rx_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
  endtask

  // Random frame of n words; bad checksum when good==0. Invalid n gives a 2-byte frame.
  task automatic build(input int n, input bit good);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    frm = {8'hA5, 8'(n)};
    if (n >= 1 && n <= 16) begin
      for (int i = 0; i < 2 * n; i++) begin
        b = 8'($urandom_range(0, 255));
        frm.push_back(b);
        x ^= b;
      end
      frm.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    end
  endtask

  task automatic run_frame(input int maxgap);
    int n = int'(frm[1]);
    int w0 = we_cnt;
    int st0;
    logic [7:0] x = 8'h00;
    logic [7:0] hi, lo;
    send_byte(frm[0]);
    check("sync_hold", cpu_hold, 1);
    check("sync_errclr", load_err, 0);
    idle($urandom_range(0, maxgap));
    st0 = stalls;
    send_byte(frm[1]);
    if (n == 0 || n > 16) begin
      check("cnt_err", load_err, 1);
      check("cnt_ready", rx_ready, 0);
      check("cnt_hold", cpu_hold, 1);
      idle(3);
      check("cnt_nowrite", we_cnt - w0, 0);
      return;
    end
    idle($urandom_range(0, maxgap));
    for (int i = 0; i < n; i++) begin
      hi = frm[2 + 2 * i];
      lo = frm[3 + 2 * i];
      send_byte(hi);
      idle($urandom_range(0, maxgap));
      send_byte(lo);
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_addr, i);
      check("wr_data", mem_wdata, {hi, lo});
      x ^= hi ^ lo;
      idle($urandom_range(0, maxgap));
    end
    send_byte(frm[2 + 2 * n]);
    if (frm[2 + 2 * n] == x) begin
      check("done_pulse", load_done, 1);
      check("done_hold", cpu_hold, 0);
      check("done_err", load_err, 0);
    end else begin
      check("bad_done", load_done, 0);
      check("bad_err", load_err, 1);
      check("bad_hold", cpu_hold, 1);
    end
    check("chk_ready", rx_ready, 0);
    if (maxgap == 0) check("no_bubbles", stalls - st0, 0);
    idle(3);
    check("done_end", load_done, 0);
    check("write_count", we_cnt - w0, n);
  endtask

  initial begin
    int w0;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    check_reset_vals();
    reset = 1'b0;
    idle(1);
    check("ready_after_rst", rx_ready, 1);

    frm = {8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_frame(0);
    frm = {8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_frame(1);
    build(3, 1'b1);
    run_frame(1);

    frm = {8'hA5, 8'h00};
    run_frame(0);
    frm = {8'hA5, 8'h11};
    run_frame(0);

    send_byte(8'h00);
    send_byte(8'hFF);
    check("junk_hold", cpu_hold, 1);
    check("junk_err", load_err, 1);
    build(2, 1'b1);
    frm[2] = 8'hA5;
    frm[6] = frm[2] ^ frm[3] ^ frm[4] ^ frm[5];
    run_frame(0);

    w0 = we_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    idle(1000);
    check("to_early_err", load_err, 0);
    check("to_early_hold", cpu_hold, 1);
    idle(30);
    check("to_err", load_err, 1);
    check("to_hold", cpu_hold, 1);
    check("to_nowrite", we_cnt - w0, 0);

    build(16, 1'b1);
    run_frame(0);

    for (int k = 0; k < 8; k++) begin
      build($urandom_range(0, 17), 1'($urandom_range(0, 1)));
      run_frame(2);
    end

    w0 = we_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    reset = 1'b1;
    idle(1);
    check_reset_vals();
    reset = 1'b0;
    idle(3);
    check("rst_writes", we_cnt - w0, 1);
    check("rst_ready_back", rx_ready, 1);
    check("rst_hold_low", cpu_hold, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
